// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/execute/writeback sequencer for the NPC core.
// Owns the PC and instruction register; halts permanently on ebreak or any fetch or jump fault.
module core_seq_ctrl #(
    parameter int                   PC_SIZE    = 32,
    parameter logic [PC_SIZE-1:0]   RESET_PC   = PC_SIZE'(32'h8000_0000),
    parameter int                   TMO_CYCLES = 256,
    parameter int                   CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    output logic                o_imem_req_valid,
    input  logic                i_imem_req_ready,
    output logic [PC_SIZE-1:0]  o_imem_addr,
    input  logic                i_imem_rsp_valid,
    input  logic [31:0]         i_imem_rsp_data,
    input  logic                i_imem_rsp_err,
    output logic [31:0]         o_instr,
    output logic [PC_SIZE-1:0]  o_pc,
    output logic                o_prdt_taken,
    output logic                o_exu_valid,
    input  logic                i_exu_done,
    input  logic                i_ebreak,
    input  logic                i_rdwen,
    input  logic                i_redirect_valid,
    input  logic [PC_SIZE-1:0]  i_redirect_pc,
    output logic                o_wb_en,
    output logic [CNT_W-1:0]    o_instret,
    output logic                o_halt,
    output logic [2:0]          o_halt_code
);

    localparam int WD_W = (TMO_CYCLES > 2) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYCLES - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [2:0] HC_EBREAK    = 3'd1;
    localparam logic [2:0] HC_FETCH_ERR = 3'd2;
    localparam logic [2:0] HC_FETCH_TMO = 3'd3;
    localparam logic [2:0] HC_MISALIGN  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t             state_reg,     state_next;
    logic [PC_SIZE-1:0] pc_reg,        pc_next;
    logic [PC_SIZE-1:0] npc_reg,       npc_next;
    logic [31:0]        ir_reg,        ir_next;
    logic [CNT_W-1:0]   instret_reg,   instret_next;
    logic [WD_W-1:0]    wdog_reg,      wdog_next;
    logic [2:0]         halt_code_reg, halt_code_next;
    logic               rdwen_reg,     rdwen_next;
    logic               fetch_tmo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            pc_reg        <= RESET_PC;
            npc_reg       <= RESET_PC;
            ir_reg        <= NOP;
            instret_reg   <= '0;
            wdog_reg      <= '0;
            halt_code_reg <= '0;
            rdwen_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            npc_reg       <= npc_next;
            ir_reg        <= ir_next;
            instret_reg   <= instret_next;
            wdog_reg      <= wdog_next;
            halt_code_reg <= halt_code_next;
            rdwen_reg     <= rdwen_next;
        end
    end

    // Watchdog is zero whenever a fetch starts, so it needs no explicit entry clear.
    assign fetch_tmo = (wdog_reg == WD_LAST);

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        npc_next       = npc_reg;
        ir_next        = ir_reg;
        instret_next   = instret_reg;
        wdog_next      = '0;
        halt_code_next = halt_code_reg;
        rdwen_next     = rdwen_reg;

        case (state_reg)
            S_IDLE: begin
                state_next = S_FETCH_REQ;
            end
            S_FETCH_REQ: begin
                wdog_next = wdog_reg + WD_W'(1);
                if (fetch_tmo) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_FETCH_TMO;
                end else if (i_imem_req_ready) begin
                    state_next = S_FETCH_WAIT;
                end
            end
            S_FETCH_WAIT: begin
                wdog_next = wdog_reg + WD_W'(1);
                // A response in the final watchdog cycle still counts.
                if (i_imem_rsp_valid) begin
                    if (i_imem_rsp_err) begin
                        state_next     = S_HALT;
                        halt_code_next = HC_FETCH_ERR;
                    end else begin
                        ir_next    = i_imem_rsp_data;
                        state_next = S_EXEC;
                    end
                end else if (fetch_tmo) begin
                    state_next     = S_HALT;
                    halt_code_next = HC_FETCH_TMO;
                end
            end
            S_EXEC: begin
                if (i_exu_done) begin
                    if (i_ebreak) begin
                        state_next     = S_HALT;
                        halt_code_next = HC_EBREAK;
                        instret_next   = instret_reg + CNT_W'(1);
                    end else if (i_redirect_valid && (i_redirect_pc[1:0] != 2'b00)) begin
                        state_next     = S_HALT;
                        halt_code_next = HC_MISALIGN;
                    end else begin
                        npc_next   = i_redirect_valid ? i_redirect_pc : (pc_reg + PC_SIZE'(4));
                        rdwen_next = i_rdwen;
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                pc_next      = npc_reg;
                instret_next = instret_reg + CNT_W'(1);
                state_next   = S_FETCH_REQ;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign o_imem_req_valid = (state_reg == S_FETCH_REQ);
    assign o_imem_addr      = pc_reg;
    assign o_instr          = ir_reg;
    assign o_pc             = pc_reg;
    assign o_prdt_taken     = 1'b0;
    assign o_exu_valid      = (state_reg == S_EXEC);
    assign o_wb_en          = (state_reg == S_WB) && rdwen_reg;
    assign o_instret        = instret_reg;
    assign o_halt           = (state_reg == S_HALT);
    assign o_halt_code      = halt_code_reg;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: acts as imem and EXU, tracks expected PC/retire/writeback
// with a simple instruction-level model.
module tb_core_seq_ctrl;

    localparam int          TMO      = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        rsp_valid = 1'b0, rsp_err = 1'b0;
    logic [31:0] rsp_data = '0;
    logic [31:0] instr, pc;
    logic        prdt_taken, exu_valid;
    logic        exu_done = 1'b0, ebreak = 1'b0, rdwen = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        wb_en, halt;
    logic [31:0] instret;
    logic [2:0]  halt_code;

    int total = 0;
    int bad = 0;
    int wb_count = 0;
    int cyc = 0;

    logic [31:0] m_pc = RESET_PC;
    int          m_instret = 0;

    core_seq_ctrl #(.TMO_CYCLES(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .o_imem_req_valid (req_valid),
        .i_imem_req_ready (req_ready),
        .o_imem_addr      (imem_addr),
        .i_imem_rsp_valid (rsp_valid),
        .i_imem_rsp_data  (rsp_data),
        .i_imem_rsp_err   (rsp_err),
        .o_instr          (instr),
        .o_pc             (pc),
        .o_prdt_taken     (prdt_taken),
        .o_exu_valid      (exu_valid),
        .i_exu_done       (exu_done),
        .i_ebreak         (ebreak),
        .i_rdwen          (rdwen),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_wb_en          (wb_en),
        .o_instret        (instret),
        .o_halt           (halt),
        .o_halt_code      (halt_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (wb_en === 1'b1) wb_count++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    task automatic do_reset();
        rst = 1'b0;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_err = 1'b0;
        exu_done = 1'b0; ebreak = 1'b0; rdwen = 1'b0; redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        m_pc = RESET_PC;
        m_instret = 0;
    endtask

    // Plays imem and EXU for one instruction; reports what it saw, leaves the checking to callers.
    task automatic do_instr(input int rdy_dly, input int rsp_dly, input int done_dly,
                            input logic [31:0] data, input logic err, input logic eb,
                            input logic wen, input logic rv, input logic [31:0] rpc,
                            output logic [31:0] addr, output int req_at,
                            output bit got_req, output bit stable, output bit exec_ok);
        got_req = 0; stable = 1; exec_ok = 1; addr = '0; req_at = 0;
        for (int i = 0; i < 60; i++) begin
            if (req_valid === 1'b1) begin
                got_req = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got_req) return;
        addr = imem_addr;
        req_at = cyc;
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            if (req_valid !== 1'b1 || imem_addr !== addr) stable = 0;
        end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        if (req_valid !== 1'b0) stable = 0;
        repeat (rsp_dly) @(negedge clk);
        rsp_valid = 1'b1; rsp_data = data; rsp_err = err;
        @(negedge clk);
        rsp_valid = 1'b0; rsp_err = 1'b0;
        $display("instr addr=%h data=%h err=%0b eb=%0b wen=%0b rv=%0b rpc=%h", addr, data, err, eb, wen, rv, rpc);
        if (err) return;
        for (int i = 0; i < done_dly; i++) begin
            if (exu_valid !== 1'b1 || instr !== data || pc !== addr) exec_ok = 0;
            @(negedge clk);
        end
        if (exu_valid !== 1'b1 || instr !== data || pc !== addr) exec_ok = 0;
        exu_done = 1'b1; ebreak = eb; rdwen = wen; redirect_valid = rv; redirect_pc = rpc;
        @(negedge clk);
        exu_done = 1'b0; ebreak = 1'b0; rdwen = 1'b0; redirect_valid = 1'b0;
        if (halt !== 1'b1) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid: got %b want 0", req_valid); end
        total++; if (exu_valid !== 1'b0) begin bad++; $display("FAIL rst_exu_valid: got %b want 0", exu_valid); end
        total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL rst_wb_en: got %b want 0", wb_en); end
        total++; if (halt !== 1'b0 || halt_code !== 3'd0) begin bad++; $display("FAIL rst_halt: got %b/%0d want 0/0", halt, halt_code); end
        total++; if (pc !== RESET_PC) begin bad++; $display("FAIL rst_pc: got %h want %h", pc, RESET_PC); end
        total++; if (instr !== NOP) begin bad++; $display("FAIL rst_ir: got %h want %h", instr, NOP); end
        total++; if (instret !== 32'd0) begin bad++; $display("FAIL rst_instret: got %0d want 0", instret); end
        total++; if (prdt_taken !== 1'b0) begin bad++; $display("FAIL rst_prdt: got %b want 0", prdt_taken); end
        rst = 1'b1;
        #1;
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", req_valid); end
        @(negedge clk);
        total++; if (req_valid !== 1'b1 || imem_addr !== RESET_PC) begin bad++; $display("FAIL first_req: got %b/%h want 1/%h", req_valid, imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [31:0] a; int at, prev_at; bit g, s, e; int wb0;
        prev_at = 0;
        for (int n = 0; n < 3; n++) begin
            wb0 = wb_count;
            do_instr(0, 0, 0, 32'h0010_0093 + 32'(n << 7), 1'b0, 1'b0, 1'b1, 1'b0, '0, a, at, g, s, e);
            total++; if (!g || a !== m_pc) begin bad++; $display("FAIL seq_addr: got %h want %h", a, m_pc); end
            total++; if (!e) begin bad++; $display("FAIL seq_exec: got bad exec view want stable instr/pc"); end
            total++; if (wb_count - wb0 != 1) begin bad++; $display("FAIL seq_wb: got %0d want 1", wb_count - wb0); end
            if (n > 0) begin
                total++; if (at - prev_at != 4) begin bad++; $display("FAIL seq_spacing: got %0d want 4", at - prev_at); end
            end
            prev_at = at;
            m_pc = m_pc + 32'd4;
            m_instret++;
        end
        total++; if (instret !== 32'(m_instret)) begin bad++; $display("FAIL seq_instret: got %0d want %0d", instret, m_instret); end
    endtask

    task automatic test_jump();
        logic [31:0] a; int at; bit g, s, e; int wb0;
        logic [31:0] tgt [4] = '{32'h8000_0100, 32'hFFFF_FFFC, 32'h0000_0000, RESET_PC};
        bit          rv   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        bit          wen  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int n = 0; n < 4; n++) begin
            wb0 = wb_count;
            do_instr(0, 0, 1, 32'h0000_006F, 1'b0, 1'b0, wen[n], rv[n], tgt[n], a, at, g, s, e);
            total++; if (!g || a !== m_pc) begin bad++; $display("FAIL jmp_addr: got %h want %h", a, m_pc); end
            total++; if (wb_count - wb0 != int'(wen[n])) begin bad++; $display("FAIL jmp_wb: got %0d want %0d", wb_count - wb0, wen[n]); end
            m_pc = rv[n] ? tgt[n] : m_pc + 32'd4;
            m_instret++;
        end
        total++; if (req_valid !== 1'b1 || imem_addr !== m_pc) begin bad++; $display("FAIL jmp_final_addr: got %h want %h", imem_addr, m_pc); end
    endtask

    task automatic test_stall(input int rdy, input int rsp, input string tag);
        logic [31:0] a; int at; bit g, s, e;
        do_instr(rdy, rsp, 2, 32'h0020_8113, 1'b0, 1'b0, 1'b1, 1'b0, '0, a, at, g, s, e);
        m_pc = m_pc + 32'd4;
        m_instret++;
        total++; if (!g || a !== m_pc - 32'd4 || !s) begin bad++; $display("FAIL %s_addr: got %h stable=%0b want %h stable=1", tag, a, s, m_pc - 32'd4); end
        total++; if (!e || halt !== 1'b0) begin bad++; $display("FAIL %s_exec: got exec_ok=%0b halt=%b want 1/0", tag, e, halt); end
        total++; if (instret !== 32'(m_instret)) begin bad++; $display("FAIL %s_instret: got %0d want %0d", tag, instret, m_instret); end
    endtask

    task automatic test_random();
        logic [31:0] a; int at; bit g, s, e; int wb0;
        logic [31:0] d, rpc; logic wen, rv;
        for (int n = 0; n < 20; n++) begin
            d   = $urandom;
            wen = 1'($urandom % 2);
            rv  = ($urandom % 4) == 0;
            rpc = RESET_PC | (32'($urandom_range(0, 1023)) << 2);
            wb0 = wb_count;
            do_instr($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                     d, 1'b0, 1'b0, wen, rv, rpc, a, at, g, s, e);
            m_instret++;
            total++; if (!g || a !== m_pc || !s) begin bad++; $display("FAIL rnd_addr: got %h want %h", a, m_pc); end
            total++; if (!e) begin bad++; $display("FAIL rnd_exec: got bad exec view for %h want stable", d); end
            total++; if (wb_count - wb0 != int'(wen)) begin bad++; $display("FAIL rnd_wb: got %0d want %0d", wb_count - wb0, wen); end
            total++; if (instret !== 32'(m_instret)) begin bad++; $display("FAIL rnd_instret: got %0d want %0d", instret, m_instret); end
            m_pc = rv ? rpc : m_pc + 32'd4;
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        n = 0;
        while (req_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (halt !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        total++; if (n != TMO) begin bad++; $display("FAIL tmo_cycles: got %0d want %0d", n, TMO); end
        total++; if (halt_code !== 3'd3 || req_valid !== 1'b0) begin bad++; $display("FAIL tmo_code: got %0d req=%b want 3/0", halt_code, req_valid); end
    endtask

    task automatic test_fetch_err();
        logic [31:0] a; int at; bit g, s, e; int wb0;
        do_reset();
        wb0 = wb_count;
        do_instr(1, 1, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, '0, a, at, g, s, e);
        total++; if (halt !== 1'b1 || halt_code !== 3'd2) begin bad++; $display("FAIL ferr_code: got %b/%0d want 1/2", halt, halt_code); end
        total++; if (exu_valid !== 1'b0 || instr !== NOP) begin bad++; $display("FAIL ferr_ir: got exu=%b ir=%h want 0/%h", exu_valid, instr, NOP); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (halt !== 1'b1 || halt_code !== 3'd2 || req_valid !== 1'b0 || exu_valid !== 1'b0) begin
                bad++; $display("FAIL ferr_sticky: got halt=%b code=%0d req=%b want 1/2/0", halt, halt_code, req_valid);
            end
        end
        total++; if (wb_count != wb0) begin bad++; $display("FAIL ferr_wb: got %0d want 0", wb_count - wb0); end
    endtask

    task automatic test_ebreak(input logic rv, input logic [31:0] rpc, input logic [2:0] want_code, input string tag);
        logic [31:0] a; int at; bit g, s, e; int wb0;
        do_reset();
        wb0 = wb_count;
        do_instr(0, 0, 0, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 1'b0, '0, a, at, g, s, e);
        m_pc = m_pc + 32'd4;
        m_instret++;
        do_instr(0, 1, 1, 32'h0010_0073, 1'b0, want_code == 3'd1, 1'b1, rv, rpc, a, at, g, s, e);
        if (want_code == 3'd1) m_instret++;
        total++; if (halt !== 1'b1 || halt_code !== want_code) begin bad++; $display("FAIL %s_code: got %b/%0d want 1/%0d", tag, halt, halt_code, want_code); end
        total++; if (instret !== 32'(m_instret)) begin bad++; $display("FAIL %s_instret: got %0d want %0d", tag, instret, m_instret); end
        total++; if (pc !== m_pc) begin bad++; $display("FAIL %s_pc: got %h want %h", tag, pc, m_pc); end
        repeat (3) @(negedge clk);
        total++; if (wb_count - wb0 != 1 || halt !== 1'b1) begin bad++; $display("FAIL %s_wb: got %0d halt=%b want 1/1", tag, wb_count - wb0, halt); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] a; int at; bit g, s, e; int n;
        do_reset();
        n = 0;
        while (req_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        do_instr(0, 0, 0, 32'h0030_0193, 1'b0, 1'b0, 1'b1, 1'b0, '0, a, at, g, s, e);
        n = 0;
        while (req_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rsp_valid = 1'b1; rsp_data = 32'hBAAD_F00D;
        repeat (2) @(negedge clk);
        rsp_valid = 1'b0;
        m_pc = RESET_PC;
        m_instret = 0;
        total++; if (instret !== 32'd0 || instr !== NOP || exu_valid !== 1'b0) begin bad++; $display("FAIL rmid_state: got instret=%0d ir=%h exu=%b want 0/%h/0", instret, instr, exu_valid, NOP); end
        do_instr(0, 0, 0, 32'h0040_0213, 1'b0, 1'b0, 1'b0, 1'b0, '0, a, at, g, s, e);
        total++; if (!g || a !== RESET_PC || !e) begin bad++; $display("FAIL rmid_first: got %h exec_ok=%0b want %h/1", a, e, RESET_PC); end
        total++; if (instret !== 32'd1) begin bad++; $display("FAIL rmid_instret: got %0d want 1", instret); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_stall(10, 5, "stall");
        test_stall(20, 10, "wdedge");
        test_random();
        test_timeout();
        test_fetch_err();
        test_ebreak(1'b0, '0, 3'd1, "ebreak");
        test_ebreak(1'b1, 32'h8000_0102, 3'd4, "misalign");
        test_ebreak(1'b1, 32'h8000_0102, 3'd1, "prio");
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
